// File: rtl/ac97_pkg.sv
// Shared AC97 deframing constants: frame/slot bit positions and the receiver state encoding.
package ac97_pkg;

  localparam int FRAME_BITS = 256;
  localparam int SLOT_BITS  = 20;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  typedef logic [CNT_W-1:0] bit_idx_t;

  // Index of the last frame bit belonging to each field, MSB-first from frame start
  localparam bit_idx_t TAG_END   = bit_idx_t'(15);
  localparam bit_idx_t SLOT1_END = bit_idx_t'(35);
  localparam bit_idx_t SLOT2_END = bit_idx_t'(55);
  localparam bit_idx_t SLOT3_END = bit_idx_t'(75);
  localparam bit_idx_t SLOT4_END = bit_idx_t'(95);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } rx_state_t;

endpackage

// File: rtl/ac97_sample_fifo.sv
// Synchronous show-ahead FIFO for record samples; reports writes dropped because it was full.
module ac97_sample_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full, do_rd, do_wr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en & ~empty;
  // A pop in the same cycle frees the slot the push needs
  assign do_wr = wr_en & (~full | do_rd);
  assign drop  = wr_en & full & ~rd_en;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ac97_frame_receiver.sv
// AC97 codec->controller deframer: tag, status readback (slots 1/2) and PCM record (slots 3/4) into a FIFO.
module ac97_frame_receiver
  import ac97_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_WIDTH  = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sync,
  input  logic                   sdata_in,
  output logic                   codec_ready,
  output logic [11:0]            slot_valid,
  output logic [6:0]             status_addr,
  output logic [15:0]            status_data,
  output logic                   status_valid,
  output logic [2*OUT_WIDTH-1:0] sample_fifo_dout,
  output logic                   sample_fifo_empty,
  input  logic                   sample_fifo_rd_en,
  output logic                   overflow,
  input  logic                   overflow_clr,
  output logic                   frame_err
);

  rx_state_t state_q, state_d;
  bit_idx_t  bit_cnt_q, bit_cnt_d, cur_bit;

  logic                   sync_d, sync_rise, active, premature;
  logic [SLOT_BITS-1:0]   shift_q, shift_d, left_q;
  logic [3:0]             slot_en_q;
  logic [6:0]             addr_q;
  logic                   push, drop;
  logic [2*OUT_WIDTH-1:0] push_data;

  // The sync_rise cycle carries frame bit 0, so it overrides the running count
  assign sync_rise = sync & ~sync_d;
  assign active    = (state_q == ST_FRAME) || sync_rise;
  assign cur_bit   = sync_rise ? '0 : bit_cnt_q;
  assign premature = (state_q == ST_FRAME) && sync_rise && (bit_cnt_q != '0);
  assign shift_d   = {shift_q[SLOT_BITS-2:0], sdata_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      sync_d    <= 1'b0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sync_d    <= sync;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sync_rise) begin
          state_d   = ST_FRAME;
          bit_cnt_d = cur_bit + 1'b1;
        end
      end
      ST_FRAME: begin
        bit_cnt_d = cur_bit + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // slot_en_q holds tag bits 14:11 (slot 1..4 valid) of the frame in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      codec_ready  <= 1'b0;
      slot_valid   <= '0;
      slot_en_q    <= '0;
      addr_q       <= '0;
      left_q       <= '0;
      status_addr  <= '0;
      status_data  <= '0;
      status_valid <= 1'b0;
      frame_err    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      status_valid <= 1'b0;
      frame_err    <= premature;
      if (active) begin
        if (cur_bit == TAG_END) begin
          codec_ready <= shift_d[15];
          slot_valid  <= shift_d[14:3];
          slot_en_q   <= shift_d[14:11];
        end
        if (cur_bit == SLOT1_END) addr_q <= shift_d[18:12];
        if (cur_bit == SLOT2_END && slot_en_q[3] && slot_en_q[2]) begin
          status_addr  <= addr_q;
          status_data  <= shift_d[19:4];
          status_valid <= 1'b1;
        end
        if (cur_bit == SLOT3_END) left_q <= shift_d;
      end
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  assign push      = active && (cur_bit == SLOT4_END) && slot_en_q[1] && slot_en_q[0];
  assign push_data = {left_q[SLOT_BITS-1 -: OUT_WIDTH], shift_d[SLOT_BITS-1 -: OUT_WIDTH]};

  ac97_sample_fifo #(
    .WIDTH (2*OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (sample_fifo_rd_en),
    .dout    (sample_fifo_dout),
    .empty   (sample_fifo_empty),
    .drop    (drop)
  );

endmodule

// File: tb/tb_ac97_frame_receiver.sv
// Randomized frame-level bench for ac97_frame_receiver with a queue-based reference model.
module tb_ac97_frame_receiver;

  localparam int DEPTH = 4;
  localparam int OW    = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sync = 1'b0;
  logic          sdata_in = 1'b0;
  logic          rd_en = 1'b0;
  logic          overflow_clr = 1'b0;
  logic          codec_ready;
  logic [11:0]   slot_valid;
  logic [6:0]    status_addr;
  logic [15:0]   status_data;
  logic          status_valid;
  logic [2*OW-1:0] dout;
  logic          empty;
  logic          overflow;
  logic          frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*OW-1:0] exp_q[$];
  bit exp_ovf = 0;
  int n_sv_seen = 0, n_sv_exp = 0, n_fe_seen = 0, n_fe_exp = 0;
  int pos = 0;
  bit in_frame = 0;

  ac97_frame_receiver #(.FIFO_DEPTH(DEPTH), .OUT_WIDTH(OW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .sync              (sync),
    .sdata_in          (sdata_in),
    .codec_ready       (codec_ready),
    .slot_valid        (slot_valid),
    .status_addr       (status_addr),
    .status_data       (status_data),
    .status_valid      (status_valid),
    .sample_fifo_dout  (dout),
    .sample_fifo_empty (empty),
    .sample_fifo_rd_en (rd_en),
    .overflow          (overflow),
    .overflow_clr      (overflow_clr),
    .frame_err         (frame_err)
  );

  always #40 clk = ~clk;

  // Pulse counters; read at posedge so they see the settled value of the previous cycle
  always @(posedge clk) begin
    if (status_valid) n_sv_seen++;
    if (frame_err)    n_fe_seen++;
  end

  // Sends one frame (or its first nbits bits) starting at the current negedge, checking
  // each field's effect one cycle after its last bit. Returns at the negedge after the last bit.
  task automatic send_frame(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                            input logic [19:0] s3, input logic [19:0] s4, input int nbits,
                            input bit use_sync, input bit exp_err, input bit pop95, input bit clr95);
    logic [255:0] f;
    bit st_ok, rec_ok, dropped;
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = $urandom;
    for (int i = 0; i < 16; i++) f[i] = tag[15-i];
    for (int i = 0; i < 20; i++) begin
      f[16+i] = s1[19-i];
      f[36+i] = s2[19-i];
      f[56+i] = s3[19-i];
      f[76+i] = s4[19-i];
    end
    st_ok  = tag[14] & tag[13];
    rec_ok = tag[12] & tag[11];
    for (int k = 0; k <= nbits; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) begin
        n_cmp++;
        if (frame_err !== exp_err) begin
          n_bad++; $display("FAIL frame_err: got %b want %b", frame_err, exp_err);
        end
        if (exp_err) n_fe_exp++;
      end
      if (k == 16) begin
        n_cmp++;
        if (codec_ready !== tag[15] || slot_valid !== tag[14:3]) begin
          n_bad++; $display("FAIL tag: got ready=%b slots=%h want ready=%b slots=%h",
                            codec_ready, slot_valid, tag[15], tag[14:3]);
        end
      end
      if (k == 56) begin
        n_cmp++;
        if (status_valid !== st_ok) begin
          n_bad++; $display("FAIL status_valid: got %b want %b", status_valid, st_ok);
        end
        if (st_ok) begin
          n_sv_exp++;
          n_cmp++;
          if (status_addr !== s1[18:12] || status_data !== s2[19:4]) begin
            n_bad++; $display("FAIL status: got %h/%h want %h/%h",
                              status_addr, status_data, s1[18:12], s2[19:4]);
          end
        end
      end
      if (k == 96) begin
        dropped = 0;
        if (pop95 && exp_q.size() > 0) void'(exp_q.pop_front());
        if (rec_ok) begin
          if (exp_q.size() < DEPTH) exp_q.push_back({s3, s4});
          else dropped = 1;
        end
        if (dropped) exp_ovf = 1;
        else if (clr95) exp_ovf = 0;
        n_cmp++;
        if (empty !== (exp_q.size() == 0)) begin
          n_bad++; $display("FAIL empty_after_slot4: got %b want %b", empty, exp_q.size() == 0);
        end
        if (exp_q.size() > 0) begin
          n_cmp++;
          if (dout !== exp_q[0]) begin
            n_bad++; $display("FAIL dout_after_slot4: got %h want %h", dout, exp_q[0]);
          end
        end
        n_cmp++;
        if (overflow !== exp_ovf) begin
          n_bad++; $display("FAIL overflow_after_slot4: got %b want %b", overflow, exp_ovf);
        end
      end
      rd_en = 1'b0;
      overflow_clr = 1'b0;
      if (k < nbits) begin
        sync = use_sync && (k < 16);
        sdata_in = f[k];
        rd_en = pop95 && (k == 95);
        overflow_clr = clr95 && (k == 95);
      end
    end
    pos = nbits % 256;
    in_frame = 1;
  endtask

  task automatic filler(input int n);
    for (int i = 0; i < n; i++) begin
      sync = 1'b0; sdata_in = 1'b0;
      @(negedge clk);
      pos = (pos + 1) % 256;
    end
  endtask

  task automatic pad_to_wrap();
    while (in_frame && pos != 0) filler(1);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      n_cmp++;
      if (empty !== 1'b0 || dout !== exp_q[0]) begin
        n_bad++; $display("FAIL drain: got empty=%b dout=%h want empty=0 dout=%h", empty, dout, exp_q[0]);
      end
      rd_en = 1'b1; sync = 1'b0; sdata_in = 1'b0;
      @(negedge clk);
      rd_en = 1'b0;
      void'(exp_q.pop_front());
      pos = (pos + 1) % 256;
    end
    rd_en = 1'b1;
    filler(1);
    rd_en = 1'b0;
    n_cmp++;
    if (empty !== 1'b1) begin
      n_bad++; $display("FAIL drain_empty: got %b want 1", empty);
    end
    pad_to_wrap();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sync = 1'b0; sdata_in = 1'b0; rd_en = 1'b0; overflow_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); exp_ovf = 0; in_frame = 0; pos = 0;
    @(negedge clk);
  endtask

  task automatic check_all_reset(input string tag);
    n_cmp++;
    if (codec_ready !== 1'b0 || slot_valid !== 12'h000 || status_addr !== 7'h00 ||
        status_data !== 16'h0000 || status_valid !== 1'b0 || dout !== '0 ||
        empty !== 1'b1 || overflow !== 1'b0 || frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b sv=%h a=%h d=%h v=%b dout=%h e=%b ovf=%b fe=%b want all 0, empty=1",
               tag, codec_ready, slot_valid, status_addr, status_data, status_valid, dout, empty,
               overflow, frame_err);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_all_reset("reset_state");
  endtask

  task automatic test_status();
    send_frame(16'hE000, {1'($urandom), 7'h26, 12'($urandom)}, {16'h000F, 4'($urandom)},
               20'($urandom), 20'($urandom), 256, 1, 0, 0, 0);
    n_cmp++;
    if (n_sv_seen !== n_sv_exp) begin
      n_bad++; $display("FAIL status_pulse_count: got %0d want %0d", n_sv_seen, n_sv_exp);
    end
  endtask

  task automatic test_record();
    send_frame(16'h9800, 20'($urandom), 20'($urandom), 20'h12345, 20'hABCDE, 256, 1, 0, 0, 0);
    drain();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++)
      send_frame(16'h9800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 256, 1, 0, 0, 0);
    overflow_clr = 1'b1;
    filler(1);
    overflow_clr = 1'b0;
    exp_ovf = 0;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++; $display("FAIL overflow_clr: got %b want 0", overflow);
    end
    pad_to_wrap();
    // clear coinciding with a drop, then push+pop while full
    send_frame(16'h9800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 256, 1, 0, 0, 1);
    send_frame(16'h9800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 256, 1, 0, 1, 0);
    drain();
  endtask

  task automatic test_frame_err();
    send_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 100, 1, 0, 0, 0);
    send_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 256, 1, 1, 0, 0);
    send_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 50, 1, 0, 0, 0);
    send_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 256, 1, 1, 0, 0);
    send_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 70, 1, 0, 0, 0);
    send_frame(16'h9800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 256, 1, 1, 0, 0);
    n_cmp++;
    if (n_sv_seen !== n_sv_exp || n_fe_seen !== n_fe_exp) begin
      n_bad++; $display("FAIL err_counts: got sv=%0d fe=%0d want sv=%0d fe=%0d",
                        n_sv_seen, n_fe_seen, n_sv_exp, n_fe_exp);
    end
    drain();
  endtask

  task automatic test_reset_mid_frame();
    send_frame(16'h9800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 256, 1, 0, 0, 0);
    send_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 71, 1, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check_all_reset("reset_mid_frame");
    exp_q.delete(); exp_ovf = 0; in_frame = 0; pos = 0;
    for (int i = 0; i < 200; i++) begin
      sync = 1'b0; sdata_in = 1'($urandom);
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
    end
    check_all_reset("idle_after_reset");
    n_cmp++;
    if (n_sv_seen !== n_sv_exp) begin
      n_bad++; $display("FAIL idle_status_count: got %0d want %0d", n_sv_seen, n_sv_exp);
    end
    send_frame(16'h9800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 256, 1, 0, 0, 0);
    drain();
  endtask

  task automatic test_invalid_slots();
    send_frame(16'h8000, 20'hFFFFF, 20'hFFFFF, 20'h55555, 20'hAAAAA, 256, 1, 0, 0, 0);
    n_cmp++;
    if (n_sv_seen !== n_sv_exp || empty !== 1'b1) begin
      n_bad++; $display("FAIL invalid_slots: got sv=%0d empty=%b want sv=%0d empty=1",
                        n_sv_seen, empty, n_sv_exp);
    end
  endtask

  task automatic test_no_sync_wrap();
    send_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 256, 1, 0, 0, 0);
    send_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 256, 0, 0, 0, 0);
    send_frame(16'h9800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 256, 1, 0, 0, 0);
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      send_frame(16'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom),
                 256, 1, 0, 1'($urandom), 1'($urandom));
    n_cmp++;
    if (n_sv_seen !== n_sv_exp || n_fe_seen !== n_fe_exp) begin
      n_bad++; $display("FAIL random_counts: got sv=%0d fe=%0d want sv=%0d fe=%0d",
                        n_sv_seen, n_fe_seen, n_sv_exp, n_fe_exp);
    end
    drain();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_status();
    test_record();
    test_overflow();
    test_frame_err();
    test_invalid_slots();
    test_no_sync_wrap();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
